// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data
// load/store. Each requester gets a req/ack handshake. Only one memory
// transaction runs at a time, and ties are broken round-robin.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abort transactions that
// stay outstanding for TIMEOUT cycles.
module mem_arbiter #(
   parameter int          TIMEOUT    = 255,
   parameter logic [31:0] ABORT_DATA = 32'hDEADBEEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        f_req,
   input  logic [31:0] f_addr,
   output logic        f_ack,
   output logic [31:0] f_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic        d_byte,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        mem_start,
   output logic        mem_we,
   output logic        mem_byte,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   input  logic        mem_write_done,
   output logic        timeout_err
);

   typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

   state_t state, state_nx;
   logic   last_grant;   // 1 = data was granted last, 0 = fetch
   logic   owner;        // requester that owns the current transaction
   logic   grant_d;      // arbitration result: 1 = data wins
   logic   any_req;
   logic   done;         // completion of the matching type while BUSY
   logic   to_hit;       // watchdog expiry (never set when done is set)
   logic [31:0] rd_word;

   assign any_req = f_req | d_req;
   assign done    = (state == BUSY) && (mem_we ? mem_write_done : mem_ready);
   assign rd_word = to_hit ? ABORT_DATA : mem_rdata;

   // Round-robin arbitration: a lone requester wins, a tie goes to the one not granted last
   always_comb begin
      grant_d = d_req;
      if (f_req && d_req)
         grant_d = ~last_grant;
   end

`ifdef MEM_ARB_TIMEOUT_EN
   logic [15:0] to_cnt;

   assign to_hit = (state == BUSY) && !done && (to_cnt == 16'(TIMEOUT));

   // Watchdog counter cleared on grant, counts BUSY cycles without completion; sticky error flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         to_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == IDLE)
            to_cnt <= '0;
         else if (state == BUSY && !done)
            to_cnt <= to_cnt + 16'd1;
         if (to_hit)
            timeout_err <= 1'b1;
      end
   end
`else
   assign to_hit      = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state logic: IDLE -> BUSY on any request, BUSY -> ACK on completion or abort
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (any_req) state_nx = BUSY;
         BUSY:    if (done || to_hit) state_nx = ACK;
         ACK:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: latch granted request, pulse start/ack, capture read data, track last grant
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_grant <= 1'b1;
         owner      <= 1'b0;
         mem_start  <= 1'b0;
         mem_we     <= 1'b0;
         mem_byte   <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         f_ack      <= 1'b0;
         d_ack      <= 1'b0;
         f_rdata    <= '0;
         d_rdata    <= '0;
      end else begin
         mem_start <= 1'b0;
         f_ack     <= 1'b0;
         d_ack     <= 1'b0;
         case (state)
            IDLE: if (any_req) begin
               owner     <= grant_d;
               mem_start <= 1'b1;
               mem_we    <= grant_d & d_we;
               mem_byte  <= grant_d & d_byte;
               mem_addr  <= grant_d ? d_addr : f_addr;
               mem_wdata <= grant_d ? d_wdata : '0;
            end
            BUSY: if (done || to_hit) begin
               f_ack <= ~owner;
               d_ack <= owner;
               // stores leave the read-data registers untouched
               if (!mem_we) begin
                  if (owner) d_rdata <= rd_word;
                  else       f_rdata <= rd_word;
               end
            end
            ACK:     last_grant <= owner;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic scored against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
   localparam int          TIMEOUT    = 8;
   localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        f_req, d_req, d_we, d_byte;
   logic [31:0] f_addr, d_addr, d_wdata, mem_rdata;
   logic        mem_ready, mem_write_done;
   logic        f_ack, d_ack, mem_start, mem_we, mem_byte, timeout_err;
   logic [31:0] f_rdata, d_rdata, mem_addr, mem_wdata;

   int checks = 0;
   int errors = 0;

   // model state
   logic [31:0] exp_f_rdata, exp_d_rdata;
   logic        m_last;   // 1 = data granted last

   mem_arbiter #(.TIMEOUT(TIMEOUT), .ABORT_DATA(ABORT_DATA)) dut (
      .clock(clock), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
      .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_start(mem_start), .mem_we(mem_we), .mem_byte(mem_byte),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .mem_write_done(mem_write_done),
      .timeout_err(timeout_err)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_byte = 0;
      d_addr = 0; d_wdata = 0; mem_rdata = 0; mem_ready = 0; mem_write_done = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      clear_inputs();
      tick();
      reset = 0;
      tick();
      exp_f_rdata = 0;
      exp_d_rdata = 0;
      m_last = 1;
   endtask

   // bounded wait for mem_start; ok=0 if it never shows
   task automatic wait_start(output bit ok);
      ok = 0;
      for (int i = 0; i < 8 && !ok; i++) begin
         tick();
         if (mem_start) ok = 1;
      end
   endtask

   task automatic test_reset();
      reset = 1;
      clear_inputs();
      tick();
      checks++;
      if ({f_ack, d_ack, mem_start, mem_we, mem_byte, timeout_err} !== 6'b0) begin
         errors++; $display("FAIL reset_ctrl got %b exp 000000",
                            {f_ack, d_ack, mem_start, mem_we, mem_byte, timeout_err});
      end
      checks++;
      if ({mem_addr, mem_wdata, f_rdata, d_rdata} !== 128'b0) begin
         errors++; $display("FAIL reset_data got %h %h %h %h exp 0", mem_addr, mem_wdata, f_rdata, d_rdata);
      end
      reset = 0;
      tick(); tick();
      checks++;
      if (mem_start !== 1'b0) begin
         errors++; $display("FAIL reset_idle mem_start got %b exp 0", mem_start);
      end
      exp_f_rdata = 0; exp_d_rdata = 0; m_last = 1;
   endtask

   task automatic test_fetch_basic();
      bit ok;
      f_addr = 32'h10; f_req = 1;
      wait_start(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL fetch_start no mem_start within bound"); end
      checks++;
      if ({mem_addr, mem_we, mem_byte} !== {32'h10, 2'b00}) begin
         errors++; $display("FAIL fetch_fields got %h %b%b exp 00000010 00", mem_addr, mem_we, mem_byte);
      end
      tick();
      checks++;
      if ({mem_start, f_ack, d_ack} !== 3'b000) begin
         errors++; $display("FAIL fetch_early got %b exp 000", {mem_start, f_ack, d_ack});
      end
      mem_ready = 1; mem_rdata = 32'h12345678;
      tick();
      mem_ready = 0; f_req = 0;
      checks++;
      if ({f_ack, d_ack} !== 2'b10) begin
         errors++; $display("FAIL fetch_ack got %b exp 10", {f_ack, d_ack});
      end
      checks++;
      if (f_rdata !== 32'h12345678) begin
         errors++; $display("FAIL fetch_rdata got %h exp 12345678", f_rdata);
      end
      tick();
      checks++;
      if ({f_ack, d_ack} !== 2'b00) begin
         errors++; $display("FAIL fetch_ack_pulse got %b exp 00", {f_ack, d_ack});
      end
      exp_f_rdata = 32'h12345678;
      m_last = 0;
   endtask

   // both held from reset; memory answers the cycle after mem_start
   task automatic test_round_robin();
      int    cyc, last_start, n_starts, n_acks, spacing_bad;
      logic  exp_owner;
      bit    resp_pending;
      logic [31:0] pend_r;
      do_reset();
      f_addr = 32'h100; d_addr = 32'h200; d_we = 0; d_byte = 0;
      f_req = 1; d_req = 1;
      cyc = 0; last_start = 0; n_starts = 0; n_acks = 0; spacing_bad = 0;
      resp_pending = 0; exp_owner = 0; pend_r = 0;
      for (int i = 0; i < 28; i++) begin
         tick();
         cyc++;
         mem_ready = 0;
         if (f_ack || d_ack) begin
            n_acks++;
            checks++;
            if ({f_ack, d_ack} !== (exp_owner ? 2'b01 : 2'b10)) begin
               errors++; $display("FAIL rr_ack_owner got %b owner %b", {f_ack, d_ack}, exp_owner);
            end
            if (exp_owner) exp_d_rdata = pend_r; else exp_f_rdata = pend_r;
            checks++;
            if ({f_rdata, d_rdata} !== {exp_f_rdata, exp_d_rdata}) begin
               errors++; $display("FAIL rr_rdata got %h %h exp %h %h", f_rdata, d_rdata, exp_f_rdata, exp_d_rdata);
            end
         end
         if (resp_pending) begin
            mem_ready = 1; mem_rdata = pend_r; resp_pending = 0;
         end
         if (mem_start) begin
            exp_owner = ~m_last;
            m_last = exp_owner;
            checks++;
            if (mem_addr !== (exp_owner ? 32'h200 : 32'h100)) begin
               errors++; $display("FAIL rr_grant got %h exp %h", mem_addr, exp_owner ? 32'h200 : 32'h100);
            end
            if (n_starts > 0 && cyc - last_start != 4) spacing_bad++;
            last_start = cyc;
            n_starts++;
            resp_pending = 1;
            pend_r = $urandom;
         end
      end
      f_req = 0; d_req = 0;
      checks++;
      if (spacing_bad != 0 || n_starts != 7 || n_acks != 7) begin
         errors++; $display("FAIL rr_spacing bad %0d starts %0d acks %0d exp 0 7 7", spacing_bad, n_starts, n_acks);
      end
      tick(); tick();
   endtask

   task automatic test_byte_store();
      bit ok;
      d_we = 1; d_byte = 1; d_addr = 32'h20; d_wdata = 32'hAB; d_req = 1;
      wait_start(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL store_start no mem_start within bound"); end
      checks++;
      if ({mem_we, mem_byte, mem_addr, mem_wdata} !== {2'b11, 32'h20, 32'hAB}) begin
         errors++; $display("FAIL store_fields got %b%b %h %h exp 11 00000020 000000ab", mem_we, mem_byte, mem_addr, mem_wdata);
      end
      mem_ready = 1; mem_rdata = 32'h55555555;
      tick();
      mem_ready = 0;
      tick();
      checks++;
      if ({f_ack, d_ack} !== 2'b00) begin
         errors++; $display("FAIL store_wrong_type got %b exp 00", {f_ack, d_ack});
      end
      mem_write_done = 1;
      tick();
      mem_write_done = 0; d_req = 0;
      checks++;
      if ({f_ack, d_ack} !== 2'b01) begin
         errors++; $display("FAIL store_ack got %b exp 01", {f_ack, d_ack});
      end
      checks++;
      if (d_rdata !== exp_d_rdata) begin
         errors++; $display("FAIL store_rdata got %h exp %h", d_rdata, exp_d_rdata);
      end
      tick();
      d_we = 0; d_byte = 0;
      m_last = 1;
   endtask

   task automatic test_reset_mid();
      bit ok;
      int bad;
      f_addr = 32'h30; f_req = 1;
      wait_start(ok);
      tick();
      reset = 1; f_req = 0;
      #1;
      checks++;
      if ({f_ack, d_ack, mem_start, mem_we, mem_byte, timeout_err, mem_addr, f_rdata, d_rdata} !== 102'b0) begin
         errors++; $display("FAIL midreset_outputs got %b %h %h %h exp 0",
                            {f_ack, d_ack, mem_start, mem_we, mem_byte, timeout_err}, mem_addr, f_rdata, d_rdata);
      end
      exp_f_rdata = 0; exp_d_rdata = 0; m_last = 1;
      tick(); tick();
      reset = 0;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (f_ack || d_ack || mem_start) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL midreset_quiet got %0d events exp 0", bad); end
      f_addr = 32'h44; f_req = 1;
      tick();
      checks++;
      if ({mem_start, mem_addr} !== {1'b1, 32'h44}) begin
         errors++; $display("FAIL midreset_regrant got %b %h exp 1 00000044", mem_start, mem_addr);
      end
      mem_ready = 1; mem_rdata = 32'hCAFE0001;
      tick();
      mem_ready = 0; f_req = 0;
      checks++;
      if ({f_ack, f_rdata} !== {1'b1, 32'hCAFE0001}) begin
         errors++; $display("FAIL midreset_fetch got %b %h exp 1 cafe0001", f_ack, f_rdata);
      end
      exp_f_rdata = 32'hCAFE0001; m_last = 0;
      tick();
   endtask

   task automatic test_random();
      bit          fp, dp, ok, win, wr, early;
      logic [31:0] fa, da, dw, rd;
      bit          dwe, dby;
      int          lat;
      fp = 0; dp = 0; fa = 0; da = 0; dw = 0; dwe = 0; dby = 0;
      for (int t = 0; t < 30; t++) begin
         if (!fp && $urandom_range(0, 1) == 1) begin fp = 1; fa = $urandom; end
         if (!dp && ($urandom_range(0, 1) == 1 || !fp)) begin
            dp = 1; da = $urandom; dw = $urandom;
            dwe = 1'($urandom_range(0, 1)); dby = dwe & 1'($urandom_range(0, 1));
         end
         f_req = fp; f_addr = fa;
         d_req = dp; d_addr = da; d_wdata = dw; d_we = dwe; d_byte = dby;
         win = (fp && dp) ? ~m_last : dp;
         wr  = win & dwe;
         wait_start(ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL rand_start[%0d] no mem_start within bound", t); end
         checks++;
         if ({mem_addr, mem_we, mem_byte} !== {(win ? da : fa), wr, win & dby}) begin
            errors++; $display("FAIL rand_fields[%0d] got %h %b%b exp %h %b%b", t, mem_addr, mem_we, mem_byte,
                               win ? da : fa, wr, win & dby);
         end
         if (wr) begin
            checks++;
            if (mem_wdata !== dw) begin
               errors++; $display("FAIL rand_wdata[%0d] got %h exp %h", t, mem_wdata, dw);
            end
         end
         lat = $urandom_range(0, 3);
         early = 0;
         for (int k = 0; k < lat; k++) begin
            mem_rdata = $urandom;
            mem_ready = wr & 1'($urandom_range(0, 1));
            mem_write_done = !wr & 1'($urandom_range(0, 1));
            tick();
            if (f_ack || d_ack) early = 1;
         end
         rd = $urandom;
         mem_rdata = rd; mem_ready = !wr; mem_write_done = wr;
         tick();
         mem_ready = 0; mem_write_done = 0;
         checks++;
         if (early || {f_ack, d_ack} !== (win ? 2'b01 : 2'b10)) begin
            errors++; $display("FAIL rand_ack[%0d] got %b early %b exp %b", t, {f_ack, d_ack}, early, win ? 2'b01 : 2'b10);
         end
         if (!wr) begin
            if (win) exp_d_rdata = rd; else exp_f_rdata = rd;
         end
         checks++;
         if ({f_rdata, d_rdata} !== {exp_f_rdata, exp_d_rdata}) begin
            errors++; $display("FAIL rand_rdata[%0d] got %h %h exp %h %h", t, f_rdata, d_rdata, exp_f_rdata, exp_d_rdata);
         end
         if (win) begin dp = 0; d_req = 0; end
         else     begin fp = 0; f_req = 0; end
         m_last = win;
         tick();
         checks++;
         if ({f_ack, d_ack, timeout_err} !== 3'b000) begin
            errors++; $display("FAIL rand_after[%0d] got %b exp 000", t, {f_ack, d_ack, timeout_err});
         end
      end
      f_req = 0; d_req = 0;
      // a request still pending from the last iteration may be granted; drain it
      for (int i = 0; i < 3; i++) begin
         mem_ready = 1; mem_write_done = 1;
         tick();
      end
      mem_ready = 0; mem_write_done = 0;
      tick(); tick();
   endtask

`ifdef MEM_ARB_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      int n;
      bit early;
      do_reset();
      // completion on the very cycle the watchdog would fire
      d_we = 0; d_addr = 32'h60; d_req = 1;
      wait_start(ok);
      early = 0;
      for (int k = 0; k < TIMEOUT; k++) begin
         tick();
         if (d_ack) early = 1;
      end
      mem_ready = 1; mem_rdata = 32'h0BADF00D;
      tick();
      mem_ready = 0; d_req = 0;
      checks++;
      if ({early, d_ack, d_rdata, timeout_err} !== {1'b0, 1'b1, 32'h0BADF00D, 1'b0}) begin
         errors++; $display("FAIL to_race got early %b ack %b %h err %b exp 0 1 0badf00d 0", early, d_ack, d_rdata, timeout_err);
      end
      tick();
      // no response at all
      d_addr = 32'h64; d_req = 1;
      wait_start(ok);
      n = 0;
      for (int k = 0; k < 20 && !d_ack; k++) begin
         tick();
         n++;
      end
      d_req = 0;
      checks++;
      if (n != TIMEOUT + 1 || d_ack !== 1'b1) begin
         errors++; $display("FAIL to_latency got %0d ack %b exp %0d 1", n, d_ack, TIMEOUT + 1);
      end
      checks++;
      if ({d_rdata, timeout_err} !== {ABORT_DATA, 1'b1}) begin
         errors++; $display("FAIL to_abort got %h %b exp deadbeef 1", d_rdata, timeout_err);
      end
      tick();
      f_addr = 32'h70; f_req = 1;
      wait_start(ok);
      mem_ready = 1; mem_rdata = 32'h11112222;
      tick();
      mem_ready = 0; f_req = 0;
      checks++;
      if ({f_ack, f_rdata, timeout_err} !== {1'b1, 32'h11112222, 1'b1}) begin
         errors++; $display("FAIL to_sticky got %b %h %b exp 1 11112222 1", f_ack, f_rdata, timeout_err);
      end
      tick();
   endtask
`endif

   initial begin
      clear_inputs();
      test_reset();
      test_fetch_basic();
      test_round_robin();
      test_byte_store();
      test_reset_mid();
      test_random();
`ifdef MEM_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
